order_sched: RTL

Round-robin order scheduler sitting between N strategy/risk requesters and the single order encoder feeding MAC TX. It accepts one order at a time from the requesters, holds its fields stable for the encoder's full two-beat frame, and waits for frame completion before granting again. It also enforces a programmable minimum inter-order gap, a kill switch and a completion timeout.

---
 rtl/order_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/order_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/order_pkg.sv
// order_pkg: shared state encodings, side constants and field widths for the order scheduler.
package order_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_e;
  localparam logic SIDE_BUY = 1'b1;
  localparam logic SIDE_SELL = 1'b0;
  localparam int PX_W = 32;
  localparam int QTY_W = 32;
  localparam int CNT_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  int k;
  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (en && req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_idx = IW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/order_sched.sv
// order_sched: round-robin order scheduler holding one order across the encoder frame,
// with kill switch, minimum inter-order gap and completion timeout.
module order_sched
  import order_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP_W = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_buy,
  input  logic [32*N_REQ-1:0]    req_px,
  input  logic [32*N_REQ-1:0]    req_qty,
  output logic                   enc_valid,
  input  logic                   enc_ready,
  output logic                   enc_buy,
  output logic [PX_W-1:0]        enc_px,
  output logic [QTY_W-1:0]       enc_qty,
  input  logic                   enc_done,
  input  logic                   kill,
  input  logic [GAP_W-1:0]       min_gap,
  output logic [2:0]             grant_id,
  output logic [CNT_W-1:0]       ord_cnt,
  output logic                   drop_pulse,
  output logic                   timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e st_q, st_d;
  logic [IW-1:0] ptr_q, ptr_d, gidx;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PX_W-1:0] px_q;
  logic [QTY_W-1:0] qty_q;
  logic [2:0] gid_q;
  logic buy_q, any, tmo_hit;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .en(st_q == ST_IDLE && !kill && !rst),
    .gnt(req_ready),
    .gnt_idx(gidx),
    .any(any)
  );
  assign tmo_hit = st_q == ST_WAIT && !enc_done && tmo_q == TW'(TIMEOUT_CYC - 1);
  assign enc_valid = st_q == ST_ISSUE && !kill && !rst;
  assign drop_pulse = st_q == ST_ISSUE && kill && !rst;
  assign timeout_err = tmo_hit && !rst;
  assign enc_buy = buy_q;
  assign enc_px = px_q;
  assign enc_qty = qty_q;
  assign grant_id = gid_q;
  assign ord_cnt = cnt_q;
  always_comb begin
    st_d = st_q;
    ptr_d = ptr_q;
    tmo_d = tmo_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    if (st_q == ST_IDLE && any) begin
      st_d = ST_ISSUE;
      ptr_d = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end
    if (st_q == ST_ISSUE) begin
      st_d = kill ? ST_IDLE : enc_ready ? ST_WAIT : ST_ISSUE;
      tmo_d = '0;
    end
    if (st_q == ST_WAIT) begin
      tmo_d = tmo_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(enc_done);
      if (enc_done || tmo_hit) begin
        st_d = (min_gap == '0) ? ST_IDLE : ST_GAP;
        gap_d = min_gap;
      end
    end
    if (st_q == ST_GAP) begin
      gap_d = gap_q - 1'b1;
      st_d = (gap_q <= GAP_W'(1)) ? ST_IDLE : ST_GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      ptr_q <= '0;
      tmo_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      buy_q <= SIDE_SELL;
      px_q <= '0;
      qty_q <= '0;
      gid_q <= '0;
    end else begin
      st_q <= st_d;
      ptr_q <= ptr_d;
      tmo_q <= tmo_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      if (any) begin
        buy_q <= req_buy[gidx];
        px_q <= req_px[32*gidx +: PX_W];
        qty_q <= req_qty[32*gidx +: QTY_W];
        gid_q <= 3'(gidx);
      end
    end
  end
endmodule
